// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO access arbiter:
//   - register address map of gpio_ip (DATA, DIR, READ)
//   - arbiter FSM state encoding
//   - gpio_access_legal(): address/direction legality check
package gpio_pkg;

    localparam logic [31:0] GPIO_DATA_ADDR = 32'h2000_0000;
    localparam logic [31:0] GPIO_DIR_ADDR  = 32'h2000_0004;
    localparam logic [31:0] GPIO_READ_ADDR = 32'h2000_0008;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    // Exact-match decode, so misaligned or out-of-map addresses fail here.
    // READ is an input-pin snapshot and cannot be written.
    function automatic logic gpio_access_legal(input logic [31:0] addr, input logic we);
        logic ok;
        ok = (addr == GPIO_DATA_ADDR) || (addr == GPIO_DIR_ADDR) || (addr == GPIO_READ_ADDR);
        if (we && (addr == GPIO_READ_ADDR)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// gpio_rr_arbiter
// Combinational round-robin pick: the first requester with req_valid set,
// searching upward from 'pointer' and wrapping at NREQ.
// Ports:
//   req_valid  in   NREQ  request vector
//   pointer    in   IDXW  highest-priority requester index
//   grant_en   in   1     grant only when set
//   grant      out  NREQ  one-hot grant (all zero when nothing granted)
//   grant_idx  out  IDXW  index of the granted requester
module gpio_rr_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDXW-1:0] pointer,
    input  logic            grant_en,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic            found;
    logic [31:0]     cand;
    logic [IDXW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (32'(pointer) + i) % NREQ;
            cand_idx = cand[IDXW-1:0];
            if (grant_en && !found && req_valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gpio_access_arbiter.sv
// gpio_access_arbiter
// Serialises register accesses from NREQ bus requesters onto the single
// gpio_ip register port. One gpio_en strobe per legal transaction; read
// data is captured after RD_LAT cycles; illegal accesses are answered with
// rsp_err and never reach gpio_ip.
// Build option: GPIO_ARB_DIRLOCK_EN - when defined, only requester 0 may
// write the DIR register; DIR writes from others complete as errors.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_we              per-requester request and direction
//   req_addr/req_wdata            NREQ x 32-bit slices, slice i = requester i
//   req_ready                     one-hot acceptance pulse
//   rsp_valid/rsp_rdata/rsp_err   one-hot completion pulse, data, error
//   busy                          FSM not in IDLE
//   gpio_en/write_enable          strobe and write qualifier to gpio_ip
//   gpio_addr/gpio_in/gpio_rdata  address, write data, read data of gpio_ip
module gpio_access_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               gpio_en,
    output logic               write_enable,
    output logic [31:0]        gpio_addr,
    output logic [31:0]        gpio_in,
    input  logic [31:0]        gpio_rdata
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned CNTW = 3;

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_next;
    logic [IDXW-1:0] grant_idx;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] owner;
    logic            lat_we;
    logic [CNTW-1:0] wait_cnt;

    logic [31:0]     addr_arr  [NREQ];
    logic [31:0]     wdata_arr [NREQ];
    logic            sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_err;
    logic            dir_locked;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*32 +: 32];
        assign wdata_arr[i] = req_wdata[i*32 +: 32];
    end

    gpio_rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req_valid (req_valid),
        .pointer   (ptr),
        .grant_en  (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef GPIO_ARB_DIRLOCK_EN
    assign dir_locked = sel_we && (sel_addr == GPIO_DIR_ADDR) && (grant_idx != '0);
`else
    assign dir_locked = 1'b0;
`endif

    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = addr_arr[grant_idx];
        sel_wdata = wdata_arr[grant_idx];
        sel_err   = !gpio_access_legal(sel_addr, sel_we) || dir_locked;
        ptr_next  = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Strobes and pulses default low every cycle and are only raised on the
    // transition into the state that owns them, so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            owner        <= '0;
            lat_we       <= 1'b0;
            wait_cnt     <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            gpio_en      <= 1'b0;
            write_enable <= 1'b0;
            gpio_addr    <= '0;
            gpio_in      <= '0;
        end else begin
            req_ready    <= '0;
            rsp_valid    <= '0;
            gpio_en      <= 1'b0;
            write_enable <= 1'b0;
            gpio_addr    <= '0;
            gpio_in      <= '0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner     <= grant;
                        lat_we    <= sel_we;
                        ptr       <= ptr_next;
                        busy      <= 1'b1;
                        req_ready <= grant;
                        if (sel_err) begin
                            state     <= ST_RESP;
                            rsp_valid <= grant;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state        <= ST_ISSUE;
                            gpio_en      <= 1'b1;
                            write_enable <= sel_we;
                            gpio_addr    <= sel_addr;
                            gpio_in      <= sel_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (lat_we) begin
                        state     <= ST_RESP;
                        rsp_valid <= owner;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    // WAIT spans RD_LAT cycles; data is sampled on the last one.
                    if (wait_cnt == CNTW'(RD_LAT - 1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= owner;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= gpio_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// tb_gpio_access_arbiter
// Directed self-checking bench for gpio_access_arbiter (NREQ=2, RD_LAT=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check observes the registered values of one cycle.
module tb_gpio_access_arbiter;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned RD_LAT = 2;

    localparam logic [31:0] A_DATA = 32'h2000_0000;
    localparam logic [31:0] A_DIR  = 32'h2000_0004;
    localparam logic [31:0] A_READ = 32'h2000_0008;

`ifdef GPIO_ARB_DIRLOCK_EN
    localparam bit DIR_LOCK = 1'b1;
`else
    localparam bit DIR_LOCK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*32-1:0] req_addr = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               busy;
    logic               gpio_en;
    logic               write_enable;
    logic [31:0]        gpio_addr;
    logic [31:0]        gpio_in;
    logic [31:0]        gpio_rdata = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_count = 0;
    int en_double = 0;
    int rsp_count = 0;
    logic en_prev = 1'b0;

    gpio_access_arbiter #(
        .NREQ   (NREQ),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .gpio_en      (gpio_en),
        .write_enable (write_enable),
        .gpio_addr    (gpio_addr),
        .gpio_in      (gpio_in),
        .gpio_rdata   (gpio_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gpio_en === 1'b1) begin
            en_count <= en_count + 1;
            if (en_prev) en_double <= en_double + 1;
        end
        en_prev <= (gpio_en === 1'b1);
        if (|rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] data);
        req_we[idx]             = we;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = data;
        req_valid[idx]          = 1'b1;
    endtask

    task automatic clr_req(input int idx);
        req_valid[idx]          = 1'b0;
        req_we[idx]             = 1'b0;
        req_addr[idx*32 +: 32]  = '0;
        req_wdata[idx*32 +: 32] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if ({req_ready, rsp_valid, rsp_err, busy, gpio_en, write_enable} !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {req_ready, rsp_valid, rsp_err, busy, gpio_en, write_enable}); end
        checks++; if (gpio_addr !== 32'h0) begin failures++; $display("FAIL reset_gpio_addr got=%h exp=00000000", gpio_addr); end
        checks++; if (gpio_in !== 32'h0) begin failures++; $display("FAIL reset_gpio_in got=%h exp=00000000", gpio_in); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00000000", rsp_rdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_dir_data();
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        int e0;
        addrs[0] = A_DIR;  datas[0] = 32'hAAAA_AAAA;
        addrs[1] = A_DATA; datas[1] = 32'hDEAD_BEEF;
        e0 = en_count;
        for (int k = 0; k < 2; k++) begin
            set_req(0, 1'b1, addrs[k], datas[k]);
            step();
            checks++; if (gpio_en !== 1'b1) begin failures++; $display("FAIL wr%0d_gpio_en got=%b exp=1", k, gpio_en); end
            checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL wr%0d_write_enable got=%b exp=1", k, write_enable); end
            checks++; if (gpio_addr !== addrs[k]) begin failures++; $display("FAIL wr%0d_gpio_addr got=%h exp=%h", k, gpio_addr, addrs[k]); end
            checks++; if (gpio_in !== datas[k]) begin failures++; $display("FAIL wr%0d_gpio_in got=%h exp=%h", k, gpio_in, datas[k]); end
            checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL wr%0d_req_ready got=%b exp=01", k, req_ready); end
            checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL wr%0d_early_rsp got=%b exp=00", k, rsp_valid); end
            clr_req(0);
            step();
            checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL wr%0d_rsp_valid got=%b exp=01", k, rsp_valid); end
            checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL wr%0d_rsp_err got=%b exp=0", k, rsp_err); end
            checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr%0d_rsp_rdata got=%h exp=00000000", k, rsp_rdata); end
            checks++; if ({gpio_en, write_enable, req_ready} !== 4'b0000) begin failures++; $display("FAIL wr%0d_resp_strobes got=%b exp=0000", k, {gpio_en, write_enable, req_ready}); end
            checks++; if (gpio_addr !== 32'h0 || gpio_in !== 32'h0) begin failures++; $display("FAIL wr%0d_bus_idle got=%h/%h exp=0/0", k, gpio_addr, gpio_in); end
            step();
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr%0d_busy_idle got=%b exp=0", k, busy); end
        end
        checks++; if (en_count - e0 !== 2) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=2", en_count - e0); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        gpio_rdata = 32'h0000_00F0;
        set_req(0, 1'b0, A_READ, 32'h0);
        set_req(1, 1'b1, A_DATA, 32'h5A5A_5A5A);
        step();
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr1_first_grant got=%b exp=01", req_ready); end
        checks++; if (gpio_addr !== A_READ || write_enable !== 1'b0) begin failures++; $display("FAIL rr1_read_issue got=%h/%b exp=%h/0", gpio_addr, write_enable, A_READ); end
        clr_req(0);
        for (int k = 0; k < RD_LAT; k++) step();
        step();
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rr1_rsp0 got=%b exp=01", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0000_00F0) begin failures++; $display("FAIL rr1_rdata got=%h exp=000000f0", rsp_rdata); end
        step();
        checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rr1_idle_gap got=%b/%b exp=00/0", req_ready, busy); end
        step();
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr1_second_grant got=%b exp=10", req_ready); end
        checks++; if (gpio_addr !== A_DATA || gpio_in !== 32'h5A5A_5A5A || write_enable !== 1'b1) begin failures++; $display("FAIL rr1_write_issue got=%h/%h/%b exp=%h/5a5a5a5a/1", gpio_addr, gpio_in, write_enable, A_DATA); end
        clr_req(1);
        step();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL rr1_rsp1 got=%b exp=10", rsp_valid); end
        step();
        // Requester 0 keeps asking; requester 1 must still get its turn.
        set_req(0, 1'b1, A_DATA, 32'h0000_0001);
        set_req(1, 1'b1, A_DATA, 32'h0000_0002);
        step();
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr2_first_grant got=%b exp=01", req_ready); end
        step();
        step();
        step();
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr2_no_starve got=%b exp=10", req_ready); end
        checks++; if (gpio_in !== 32'h0000_0002) begin failures++; $display("FAIL rr2_wdata got=%h exp=00000002", gpio_in); end
        clr_req(0);
        clr_req(1);
        step();
        step();
    endtask

    task automatic test_read_latency();
        gpio_rdata = 32'h1111_1111;
        set_req(0, 1'b0, A_READ, 32'h0);
        step();
        checks++; if (gpio_en !== 1'b1 || req_ready !== 2'b01) begin failures++; $display("FAIL rd_issue got=%b/%b exp=1/01", gpio_en, req_ready); end
        clr_req(0);
        for (int k = 0; k < RD_LAT; k++) begin
            step();
            checks++; if (rsp_valid !== 2'b00 || gpio_en !== 1'b0) begin failures++; $display("FAIL rd_wait%0d got=%b/%b exp=00/0", k, rsp_valid, gpio_en); end
            if (k == RD_LAT - 1) gpio_rdata = 32'hCAFE_BABE;
        end
        step();
        gpio_rdata = 32'h1111_1111;
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hCAFE_BABE) begin failures++; $display("FAIL rd_rdata got=%h exp=cafebabe", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp_err got=%b exp=0", rsp_err); end
        step();
        checks++; if (rsp_rdata !== 32'h0 || rsp_valid !== 2'b00) begin failures++; $display("FAIL rd_rdata_clear got=%h/%b exp=0/00", rsp_rdata, rsp_valid); end
    endtask

    task automatic test_errors();
        int          idx  [3];
        logic        we   [3];
        logic [31:0] addr [3];
        logic [1:0]  oh;
        int          e0;
        idx[0] = 0; we[0] = 1'b1; addr[0] = 32'h2000_000C;
        idx[1] = 1; we[1] = 1'b1; addr[1] = A_READ;
        idx[2] = 0; we[2] = 1'b0; addr[2] = 32'h2000_0002;
        e0 = en_count;
        for (int k = 0; k < 3; k++) begin
            oh = 2'b01 << idx[k];
            set_req(idx[k], we[k], addr[k], 32'h1234_5678);
            step();
            checks++; if (rsp_valid !== oh) begin failures++; $display("FAIL err%0d_rsp_valid got=%b exp=%b", k, rsp_valid, oh); end
            checks++; if (req_ready !== oh) begin failures++; $display("FAIL err%0d_req_ready got=%b exp=%b", k, req_ready, oh); end
            checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL err%0d_rsp_err got=%b exp=1", k, rsp_err); end
            checks++; if (gpio_en !== 1'b0 || gpio_addr !== 32'h0) begin failures++; $display("FAIL err%0d_no_strobe got=%b/%h exp=0/0", k, gpio_en, gpio_addr); end
            checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL err%0d_rsp_rdata got=%h exp=00000000", k, rsp_rdata); end
            clr_req(idx[k]);
            step();
            checks++; if (busy !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL err%0d_idle got=%b/%b exp=0/0", k, busy, rsp_err); end
        end
        checks++; if (en_count !== e0) begin failures++; $display("FAIL err_strobe_count got=%0d exp=%0d", en_count, e0); end
    endtask

    task automatic test_dirlock();
        logic exp_en;
        exp_en = !DIR_LOCK;
        set_req(1, 1'b1, A_DIR, 32'hFFFF_FFFF);
        step();
        checks++; if (gpio_en !== exp_en) begin failures++; $display("FAIL lock_req1_gpio_en got=%b exp=%b", gpio_en, exp_en); end
        checks++; if (rsp_err !== DIR_LOCK) begin failures++; $display("FAIL lock_req1_rsp_err got=%b exp=%b", rsp_err, DIR_LOCK); end
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL lock_req1_ready got=%b exp=10", req_ready); end
        clr_req(1);
        if (!DIR_LOCK) step();
        step();
        set_req(0, 1'b1, A_DIR, 32'hFFFF_FFFF);
        step();
        checks++; if (gpio_en !== 1'b1 || gpio_addr !== A_DIR || gpio_in !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lock_req0_issue got=%b/%h/%h exp=1/%h/ffffffff", gpio_en, gpio_addr, gpio_in, A_DIR); end
        clr_req(0);
        step();
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin failures++; $display("FAIL lock_req0_rsp got=%b/%b exp=01/0", rsp_valid, rsp_err); end
        step();
    endtask

    task automatic test_reset_mid();
        int r0;
        gpio_rdata = 32'h7777_7777;
        set_req(0, 1'b0, A_READ, 32'h0);
        step();
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_grant got=%b exp=01", req_ready); end
        clr_req(0);
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_wait_busy got=%b exp=1", busy); end
        r0 = rsp_count;
        rst = 1'b1;
        step();
        checks++; if ({req_ready, rsp_valid, rsp_err, busy, gpio_en, write_enable} !== 8'h00) begin failures++; $display("FAIL mid_reset_ctrl got=%b exp=00000000", {req_ready, rsp_valid, rsp_err, busy, gpio_en, write_enable}); end
        checks++; if (rsp_rdata !== 32'h0 || gpio_addr !== 32'h0 || gpio_in !== 32'h0) begin failures++; $display("FAIL mid_reset_data got=%h/%h/%h exp=0/0/0", rsp_rdata, gpio_addr, gpio_in); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checks++; if (rsp_count !== r0) begin failures++; $display("FAIL mid_no_rsp got=%0d exp=%0d", rsp_count, r0); end
        set_req(0, 1'b1, A_DATA, 32'h0000_00AA);
        set_req(1, 1'b1, A_DATA, 32'h0000_00BB);
        step();
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_ptr_reset got=%b exp=01", req_ready); end
        clr_req(0);
        clr_req(1);
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int stamp [2];
        int n;
        n = 0;
        stamp[0] = 0;
        stamp[1] = 0;
        set_req(0, 1'b1, A_DATA, 32'h1234_5678);
        for (int k = 0; k < 12 && n < 2; k++) begin
            step();
            if (gpio_en === 1'b1) begin
                stamp[n] = cyc;
                n++;
            end
        end
        clr_req(0);
        checks++; if (n !== 2) begin failures++; $display("FAIL b2b_timeout got=%0d strobes exp=2", n); end
        checks++; if (stamp[1] - stamp[0] !== 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", stamp[1] - stamp[0]); end
        step();
        step();
        checks++; if (en_double !== 0) begin failures++; $display("FAIL gpio_en_consecutive got=%0d exp=0", en_double); end
    endtask

    initial begin
        test_reset();
        test_write_dir_data();
        test_round_robin();
        test_read_latency();
        test_errors();
        test_dirlock();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
